// File: rtl/alu_issue_unit.sv
// Issue unit for a multi-cycle combinational ALU: registers a request onto the ALU,
// waits SETTLE cycles, captures the result and holds it until the consumer accepts.
module alu_issue_unit #(
    parameter int WIDTH  = 23,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH:0]   req_a,
    input  logic [WIDTH:0]   req_b,
    input  logic [1:0]       req_op,
    input  logic             req_ci,

    output logic [WIDTH:0]   alu_a,
    output logic [WIDTH:0]   alu_b,
    output logic [1:0]       alu_op,
    output logic             alu_ci,

    input  logic [WIDTH:0]   alu_out,
    input  logic             alu_co,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_c,
    input  logic             alu_v,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH:0]   rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             rsp_co,

    input  logic             clr_sticky,
    output logic [3:0]       sticky_flags,
    output logic [15:0]      op_count
);

    localparam logic [1:0] OP_DIV     = 2'b10;
    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
        $error("alu_issue_unit: SETTLE must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        HOLD
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [3:0]   settle_cnt;

    logic         accept;
    logic         capture;
    logic         complete;
    logic         div_zero;
    logic [WIDTH:0] cap_result;
    logic [3:0]   cap_flags;
    logic         cap_co;

    // State register only; every decision lives in the combinational process below.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignment so every register
        // samples pre-edge values regardless of statement or process ordering.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_next = state;
        req_ready  = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        complete   = 1'b0;

        case (state)
            IDLE: begin
                req_ready = !rst;
                accept    = req_valid && !rst;
                if (accept) begin
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                capture = (settle_cnt == SETTLE_CNT);
                if (capture) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                complete = rsp_ready;
                if (complete) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // alu_* cannot change outside an accept, so divide-by-zero can be judged from them.
    always_comb begin
        div_zero = (alu_op == OP_DIV) && (alu_b == '0);
        if (div_zero) begin
            cap_result = '1;
            cap_flags  = 4'b0001;
            cap_co     = 1'b0;
        end else begin
            cap_result = alu_out;
            cap_flags  = {alu_n, alu_z, alu_c, alu_v};
            cap_co     = alu_co;
        end
    end

    // ALU drive registers and settle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= 2'b00;
            alu_ci     <= 1'b0;
            settle_cnt <= 4'd0;
        end else begin
            if (accept) begin
                alu_a      <= req_a;
                alu_b      <= req_b;
                alu_op     <= req_op;
                alu_ci     <= req_ci;
                settle_cnt <= 4'd1;
            end else if (capture) begin
                settle_cnt <= 4'd0;
            end else if (state == DRIVE) begin
                settle_cnt <= settle_cnt + 4'd1;
            end
        end
    end

    // Response, sticky flags and completion counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_flags    <= 4'b0000;
            rsp_co       <= 1'b0;
            sticky_flags <= 4'b0000;
            op_count     <= 16'd0;
        end else begin
            if (capture) begin
                rsp_valid  <= 1'b1;
                rsp_result <= cap_result;
                rsp_flags  <= cap_flags;
                rsp_co     <= cap_co;
            end else if (complete) begin
                rsp_valid <= 1'b0;
                op_count  <= op_count + 16'd1;
            end

            // A clear coinciding with a capture keeps only the freshly captured flags.
            if (capture) begin
                sticky_flags <= clr_sticky ? cap_flags : (sticky_flags | cap_flags);
            end else if (clr_sticky) begin
                sticky_flags <= 4'b0000;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit; a small behavioural ALU answers the registered drive.
module tb_alu_issue_unit;

    localparam int WIDTH  = 23;
    localparam int SETTLE = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [WIDTH:0]    req_a = '0;
    logic [WIDTH:0]    req_b = '0;
    logic [1:0]        req_op = 2'b00;
    logic              req_ci = 1'b0;
    logic [WIDTH:0]    alu_a;
    logic [WIDTH:0]    alu_b;
    logic [1:0]        alu_op;
    logic              alu_ci;
    logic [WIDTH:0]    alu_out;
    logic              alu_co;
    logic              alu_n;
    logic              alu_z;
    logic              alu_c;
    logic              alu_v;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [WIDTH:0]    rsp_result;
    logic [3:0]        rsp_flags;
    logic              rsp_co;
    logic              clr_sticky = 1'b0;
    logic [3:0]        sticky_flags;
    logic [15:0]       op_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_issue_unit #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_ci(req_ci),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_ci(alu_ci),
        .alu_out(alu_out), .alu_co(alu_co),
        .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_co(rsp_co),
        .clr_sticky(clr_sticky), .sticky_flags(sticky_flags), .op_count(op_count)
    );

    // Behavioural ALU: divide-by-zero returns junk that the unit must ignore.
    always_comb begin
        logic [WIDTH+1:0] wide;
        wide   = '0;
        alu_co = 1'b0;
        case (alu_op)
            2'b00: begin
                wide    = {1'b0, alu_a} + {1'b0, alu_b} + {{WIDTH+1{1'b0}}, alu_ci};
                alu_out = wide[WIDTH:0];
                alu_co  = wide[WIDTH+1];
            end
            2'b01: alu_out = alu_a * alu_b;
            2'b10: alu_out = (alu_b != '0) ? alu_a / alu_b : 24'h800123;
            default: begin
                wide    = {1'b0, alu_a} - {1'b0, alu_b} - {{WIDTH+1{1'b0}}, alu_ci};
                alu_out = wide[WIDTH:0];
                alu_co  = wide[WIDTH+1];
            end
        endcase
        alu_n = alu_out[WIDTH];
        alu_z = (alu_out == '0);
        alu_c = alu_co;
        alu_v = (alu_op == 2'b10) && (alu_b == '0) ? 1'b0 : 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request and returns 1 time unit after the accepting edge.
    task automatic issue(input logic [WIDTH:0] a, input logic [WIDTH:0] b,
                         input logic [1:0] op, input logic ci);
        req_a = a; req_b = b; req_op = op; req_ci = ci; req_valid = 1'b1;
        for (int i = 0; i < 20 && !req_ready; i++) tick();
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++; $display("FAIL issue_wait req_ready=%b expected 1", req_ready);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        n_cmp++; if ({rsp_result, rsp_flags, rsp_co} !== 29'd0) begin n_err++; $display("FAIL rst_rsp got=%h/%b/%b exp=0", rsp_result, rsp_flags, rsp_co); end
        n_cmp++; if ({alu_a, alu_b, alu_op, alu_ci} !== 51'd0) begin n_err++; $display("FAIL rst_alu got=%h/%h/%b/%b exp=0", alu_a, alu_b, alu_op, alu_ci); end
        n_cmp++; if ({sticky_flags, op_count} !== 20'd0) begin n_err++; $display("FAIL rst_counters got=%b/%h exp=0", sticky_flags, op_count); end
        rst = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_add();
        issue(24'd5, 24'd5, 2'b00, 1'b0);
        n_cmp++; if ({alu_a, alu_b, alu_op} !== {24'd5, 24'd5, 2'b00}) begin n_err++; $display("FAIL add_drive got=%h/%h/%b exp=5/5/00", alu_a, alu_b, alu_op); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL add_early_valid got=%b exp=0", rsp_valid); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL add_latency got=%b exp=1", rsp_valid); end
        n_cmp++; if (rsp_result !== 24'h00000A) begin n_err++; $display("FAIL add_result got=%h exp=00000a", rsp_result); end
        n_cmp++; if ({rsp_flags, rsp_co} !== 5'b00000) begin n_err++; $display("FAIL add_flags got=%b/%b exp=0000/0", rsp_flags, rsp_co); end
        finish_rsp();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL add_done_valid got=%b exp=0", rsp_valid); end
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL add_done_ready got=%b exp=1", req_ready); end
        n_cmp++; if (op_count !== 16'd1) begin n_err++; $display("FAIL add_op_count got=%0d exp=1", op_count); end
    endtask

    task automatic test_sub_sticky();
        issue(24'd5, 24'd5, 2'b11, 1'b0);
        tick(); tick();
        n_cmp++; if (rsp_result !== 24'd0) begin n_err++; $display("FAIL sub_result got=%h exp=0", rsp_result); end
        n_cmp++; if (rsp_flags !== 4'b0100) begin n_err++; $display("FAIL sub_flags got=%b exp=0100", rsp_flags); end
        n_cmp++; if (sticky_flags !== 4'b0100) begin n_err++; $display("FAIL sub_sticky got=%b exp=0100", sticky_flags); end
        finish_rsp();
        issue(24'd1, 24'd2, 2'b00, 1'b0);
        tick(); tick();
        n_cmp++; if ({rsp_result, rsp_flags} !== {24'd3, 4'b0000}) begin n_err++; $display("FAIL add2_rsp got=%h/%b exp=3/0000", rsp_result, rsp_flags); end
        n_cmp++; if (sticky_flags !== 4'b0100) begin n_err++; $display("FAIL sticky_keep got=%b exp=0100", sticky_flags); end
        finish_rsp();
        n_cmp++; if (op_count !== 16'd3) begin n_err++; $display("FAIL sub_op_count got=%0d exp=3", op_count); end
    endtask

    task automatic test_div();
        issue(24'd13, 24'd3, 2'b10, 1'b0);
        tick(); tick();
        n_cmp++; if ({rsp_valid, rsp_result, rsp_flags} !== {1'b1, 24'd4, 4'b0000}) begin n_err++; $display("FAIL div_rsp got=%b/%h/%b exp=1/4/0000", rsp_valid, rsp_result, rsp_flags); end
        finish_rsp();
        issue(24'd7, 24'd0, 2'b10, 1'b0);
        tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL div0_early_valid got=%b exp=0", rsp_valid); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL div0_latency got=%b exp=1", rsp_valid); end
        n_cmp++; if (rsp_result !== 24'hFFFFFF) begin n_err++; $display("FAIL div0_result got=%h exp=ffffff", rsp_result); end
        n_cmp++; if ({rsp_flags, rsp_co} !== 5'b00010) begin n_err++; $display("FAIL div0_flags got=%b/%b exp=0001/0", rsp_flags, rsp_co); end
        finish_rsp();
        n_cmp++; if (op_count !== 16'd5) begin n_err++; $display("FAIL div_op_count got=%0d exp=5", op_count); end
        n_cmp++; if (sticky_flags !== 4'b0101) begin n_err++; $display("FAIL div_sticky got=%b exp=0101", sticky_flags); end
    endtask

    task automatic test_back_to_back();
        issue(24'd3, 24'd4, 2'b01, 1'b0);
        tick(); tick();
        n_cmp++; if ({rsp_valid, rsp_result} !== {1'b1, 24'd12}) begin n_err++; $display("FAIL mul_rsp got=%b/%h exp=1/00000c", rsp_valid, rsp_result); end
        req_a = 24'd9; req_b = 24'd1; req_op = 2'b00; req_ci = 1'b0; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if ({rsp_valid, rsp_result, rsp_flags, rsp_co} !== {1'b1, 24'd12, 4'b0000, 1'b0}) begin n_err++; $display("FAIL bp_hold_rsp[%0d] got=%b/%h/%b/%b exp=1/00000c/0000/0", i, rsp_valid, rsp_result, rsp_flags, rsp_co); end
            n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_req_ready[%0d] got=%b exp=0", i, req_ready); end
            n_cmp++; if ({alu_a, alu_b, alu_op} !== {24'd3, 24'd4, 2'b01}) begin n_err++; $display("FAIL bp_alu[%0d] got=%h/%h/%b exp=3/4/01", i, alu_a, alu_b, alu_op); end
        end
        finish_rsp();
        n_cmp++; if ({rsp_valid, req_ready} !== 2'b01) begin n_err++; $display("FAIL bp_release got valid=%b ready=%b exp 0/1", rsp_valid, req_ready); end
        n_cmp++; if (op_count !== 16'd6) begin n_err++; $display("FAIL bp_op_count got=%0d exp=6", op_count); end
        tick();
        req_valid = 1'b0;
        n_cmp++; if ({alu_a, alu_b, alu_op, req_ready} !== {24'd9, 24'd1, 2'b00, 1'b0}) begin n_err++; $display("FAIL bp_next_accept got=%h/%h/%b ready=%b exp=9/1/00/0", alu_a, alu_b, alu_op, req_ready); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_next_early got=%b exp=0", rsp_valid); end
        tick();
        n_cmp++; if ({rsp_valid, rsp_result} !== {1'b1, 24'd10}) begin n_err++; $display("FAIL bp_next_rsp got=%b/%h exp=1/00000a", rsp_valid, rsp_result); end
        finish_rsp();
        n_cmp++; if (op_count !== 16'd7) begin n_err++; $display("FAIL bp_final_count got=%0d exp=7", op_count); end
    endtask

    task automatic test_reset_mid_op();
        issue(24'd1, 24'd1, 2'b00, 1'b1);
        rst = 1'b1;
        tick();
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready got=%b exp=0", req_ready); end
        n_cmp++; if ({rsp_valid, rsp_result, rsp_flags, rsp_co} !== 30'd0) begin n_err++; $display("FAIL mid_rst_rsp got=%b/%h/%b/%b exp=0", rsp_valid, rsp_result, rsp_flags, rsp_co); end
        n_cmp++; if ({alu_a, alu_b, alu_op, alu_ci} !== 51'd0) begin n_err++; $display("FAIL mid_rst_alu got=%h/%h/%b/%b exp=0", alu_a, alu_b, alu_op, alu_ci); end
        n_cmp++; if ({sticky_flags, op_count} !== 20'd0) begin n_err++; $display("FAIL mid_rst_counters got=%b/%h exp=0", sticky_flags, op_count); end
        rst = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_release got=%b exp=1", req_ready); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_ghost[%0d] got=%b exp=0", i, rsp_valid); end
        end
    endtask

    task automatic test_clr_sticky();
        issue(24'h800000, 24'd0, 2'b00, 1'b0);
        tick(); tick();
        n_cmp++; if (rsp_flags !== 4'b1000) begin n_err++; $display("FAIL neg_flags got=%b exp=1000", rsp_flags); end
        finish_rsp();
        n_cmp++; if (sticky_flags !== 4'b1000) begin n_err++; $display("FAIL neg_sticky got=%b exp=1000", sticky_flags); end
        issue(24'd5, 24'd5, 2'b11, 1'b0);
        tick();
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL clr_capture_valid got=%b exp=1", rsp_valid); end
        n_cmp++; if (sticky_flags !== 4'b0100) begin n_err++; $display("FAIL clr_with_capture got=%b exp=0100", sticky_flags); end
        finish_rsp();
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        n_cmp++; if (sticky_flags !== 4'b0000) begin n_err++; $display("FAIL clr_idle got=%b exp=0000", sticky_flags); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub_sticky();
        test_div();
        test_back_to_back();
        test_reset_mid_op();
        test_clr_sticky();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
